poly_tone_synth: RTL
====================

Name: poly_tone_synth

Overview:
- Parametrised polyphonic square-wave synthesiser.
- Decodes raw PS/2 scan-code bytes into note on/off, octave and accidental commands.
- Runs up to 12 independent voice oscillators and mixes them into one saturated signed sample for the audio-controller write port.
- Sits between PS2_Controller and Audio_Controller; replaces hand-unrolled per-note logic with a generated voice array.

Parameters:
- NUM_VOICES, 7, number of voices/keys (1..12); voice i maps to key-table entry i.
- AMP_W, 32, sample width, signed two's complement.
- AMPLITUDE, 10000000, per-voice square-wave magnitude.
- CLK_HZ, 50000000, clock frequency used for half-period constants.
- HP_W, 24, half-period counter width.
- OCT_MIN, -4, lowest octave offset.
- OCT_MAX, 4, highest octave offset.
- RELEASE_CYCLES, 5000000, release length (optional feature only).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- key_data  in  8  PS/2 byte from PS2_Controller.
- key_valid  in  1  one-cycle strobe qualifying key_data.
- sample_ready  in  1  audio_out_allowed from Audio_Controller.
- sample_out  out  AMP_W  mixed sample, signed.
- sample_write  out  1  write strobe to Audio_Controller.
- voice_active  out  NUM_VOICES  held-key flags, for LEDs.
- octave  out  4  signed current octave offset.
- sharp  out  1  sharp mode.
- flat  out  1  flat mode.

Behaviour:
- Reset clears all outputs to 0, parser to IDLE, all voice counters and phases to 0, octave to 0.
- Parser FSM; all transitions occur only on key_valid.
  - IDLE: byte F0 goes to BRK; E0 goes to EXT; a table note code sets that voice active (note-on); any other byte is ignored.
  - BRK: a note code clears that voice (note-off); any byte returns to IDLE.
  - EXT: F0 goes to EXT_BRK. 75 increments octave, 72 decrements, 6B toggles flat, 74 toggles sharp; each then returns to IDLE. Any other byte returns to IDLE.
  - EXT_BRK: any byte returns to IDLE; arrow releases are ignored.
- Octave saturates at OCT_MAX and OCT_MIN; it never wraps.
- Key table (package), entries 0..11: 16,1E,26,25,2E,36,3D,3E,46,45,4E,55. Base notes: A4 B4 C5 D5 E5 F5 G5 A5 B5 C6 D6 E6.
- Pitch latch at note-on: half_period = HP[note][acc] >> octave if octave ≥ 0, else << -octave.
  - acc is SHARP if sharp=1 (sharp wins over flat), FLAT if only flat=1, otherwise NAT.
  - Latched pitch is held while the key is held; later octave or accidental changes do not retune a sounding voice.
  - Re-press of an already-active key (typematic repeat) relatches pitch but does not reset phase.
- Voice oscillator:
  - Counter counts 0..half_period-1 while active; at half_period-1 it wraps to 0 and toggles phase.
  - On note-off, counter and phase are cleared on the next cycle.
- Mixer:
  - Each voice contributes +AMPLITUDE when its phase is 1, -AMPLITUDE when 0, and 0 when inactive.
  - Contributions are summed in AMP_W+4 bits, saturated to the AMP_W signed range, and registered into sample_out.
  - Latency is one cycle from a phase change to sample_out.
- Handshake:
  - sample_write equals sample_ready, registered alongside sample_out, so each write carries the current mix.
  - There is no buffering; samples are dropped when sample_ready is low.
- Simultaneous events: a note-on for voice i and its wrap in the same cycle resolve as note-on (counter reset to 0, phase 0).
- Reset mid-note silences output on the following cycle.

Optional Feature:
- Macro SYNTH_RELEASE_EN.
- Enabled:
  - Note-off starts a release timer of RELEASE_CYCLES; the voice keeps oscillating at AMPLITUDE>>1.
  - The voice goes silent when the timer expires.
  - A re-press during release restores full amplitude and cancels the timer.
  - voice_active reflects held keys only.
- Disabled: note-off silences the voice immediately; no timer logic is present.

Decomposition:
- Package synth_pkg holds:
  - scan-code constants (F0, E0, arrow codes) and the 12-entry key table;
  - accidental enum {NAT, SHARP, FLAT};
  - parser-state enum;
  - a constant function computing HP[note][acc] = round(CLK_HZ / (2·f)), with f scaled by 2^(±1/12) for sharp/flat.
- One sub-module, synth_voice: counter, phase, half-period latch, optional release timer. Instantiated NUM_VOICES times by generate.

Test Plan:
- Reset, then bytes 16 → voice_active=0000001; sample_out alternates +10000000/-10000000 with a half-period of 56818 cycles.
- Bytes E0 75, then 16 → octave=1, half-period 28409; bytes F0 16 → sample_out=0 within 2 cycles.
- Bytes 16, 1E held together → sample_out takes values in {20000000, 0, -20000000}; release 16 → only ±10000000.
- AMPLITUDE=2^30, NUM_VOICES=3, all keys pressed with phases aligned → sample_out=2^31-1, then -2^31 (saturated).
- Six E0 75 sequences → octave=4; E0 74 → sharp=1; E0 6B → flat=1; press 16 → half-period 53629 >> 4 = 3351 (sharp wins).
- Reset asserted mid-tone → next cycle sample_out=0, voice_active=0, octave=0, parser returns to IDLE (a following 16 is a note-on).

Source files
------------

// File: rtl/synth_pkg.sv
// Shared scan codes, key table, accidental/parser enums and the half-period
// helper used by poly_tone_synth and synth_voice.
package synth_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int MAX_VOICES = 12;
  localparam logic [7:0] KEY_TABLE [MAX_VOICES] = '{
    8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46, 8'h45, 8'h4E, 8'h55
  };

  // 2^(1/12) scaled by 1e6
  localparam longint SEMI_PPM = 1059463;

  typedef enum logic [1:0] {NAT, SHARP, FLAT} acc_e;
  typedef enum logic [1:0] {P_IDLE, P_BRK, P_EXT, P_EXT_BRK} parse_state_e;

  // Base note frequencies in milli-hertz, A4 .. E6.
  function automatic longint note_mhz(input int note);
    case (note)
      0:       return 440000;
      1:       return 493883;
      2:       return 523251;
      3:       return 587330;
      4:       return 659255;
      5:       return 698456;
      6:       return 783991;
      7:       return 880000;
      8:       return 987767;
      9:       return 1046502;
      10:      return 1174659;
      default: return 1318510;
    endcase
  endfunction

  // Rounded CLK_HZ / (2 f), with f shifted one semitone for sharp/flat.
  function automatic longint hp_calc(input longint clk_hz, input int note, input acc_e acc);
    longint f;
    f = note_mhz(note);
    case (acc)
      SHARP:   f = (f * SEMI_PPM) / 1000000;
      FLAT:    f = (f * 1000000) / SEMI_PPM;
      default: f = f;
    endcase
    return (clk_hz * 1000 + f) / (2 * f);
  endfunction

endpackage

// File: rtl/synth_voice.sv
// Single square-wave voice: pitch latch, half-period counter and phase.
// SYNTH_RELEASE_EN adds a half-amplitude release tail after note-off.
module synth_voice
  import synth_pkg::*;
#(
  parameter int     AMP_W          = 32,
  parameter longint AMPLITUDE      = 10000000,
  parameter int     HP_W           = 24,
  parameter int     RELEASE_CYCLES = 5000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             note_on,
  input  logic             note_off,
  input  logic [HP_W-1:0]  hp_in,
  output logic             active,
  output logic [AMP_W-1:0] contrib
);

  localparam logic [AMP_W-1:0] AMP_FULL = AMP_W'(AMPLITUDE);

  logic [HP_W-1:0]  hp_q, cnt_q;
  logic             phase_q, active_q;
  logic             sounding, silence, wrap;
  logic [AMP_W-1:0] mag;

`ifdef SYNTH_RELEASE_EN
  localparam int REL_W = $clog2(RELEASE_CYCLES + 1);
  localparam logic [AMP_W-1:0] AMP_HALF = AMP_W'(AMPLITUDE >>> 1);

  logic             rel_q;
  logic [REL_W-1:0] timer_q;

  assign sounding = active_q | rel_q;
  assign mag      = active_q ? AMP_FULL : AMP_HALF;
  assign silence  = !note_on && rel_q && (timer_q == '0);

  always_ff @(posedge clk) begin
    if (reset || note_on) begin
      rel_q   <= 1'b0;
      timer_q <= '0;
    end else if (note_off && active_q) begin
      rel_q   <= 1'b1;
      timer_q <= REL_W'(RELEASE_CYCLES - 1);
    end else if (rel_q) begin
      if (timer_q == '0) rel_q <= 1'b0;
      else               timer_q <= timer_q - REL_W'(1);
    end
  end
`else
  assign sounding = active_q;
  assign mag      = AMP_FULL;
  assign silence  = note_off;
`endif

  assign wrap = (cnt_q >= hp_q - HP_W'(1));

  // A press on a silent voice, or one landing on a wrap, restarts the phase;
  // a typematic repeat on a sounding voice only relatches the pitch.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_q <= 1'b0;
      hp_q     <= '0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else if (note_on) begin
      active_q <= 1'b1;
      hp_q     <= hp_in;
      if (!sounding || wrap) begin
        cnt_q   <= '0;
        phase_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q + HP_W'(1);
      end
    end else if (silence) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      phase_q  <= 1'b0;
    end else begin
      if (note_off) active_q <= 1'b0;
      if (sounding) begin
        if (wrap) begin
          cnt_q   <= '0;
          phase_q <= !phase_q;
        end else begin
          cnt_q <= cnt_q + HP_W'(1);
        end
      end
    end
  end

  assign active  = active_q;
  assign contrib = sounding ? (phase_q ? mag : AMP_W'(0) - mag) : '0;

endmodule

// File: rtl/poly_tone_synth.sv
// PS/2-driven polyphonic square-wave synth: scan-code parser, voice array
// and saturating mixer. Optional release tail via SYNTH_RELEASE_EN.
module poly_tone_synth
  import synth_pkg::*;
#(
  parameter int     NUM_VOICES     = 7,
  parameter int     AMP_W          = 32,
  parameter longint AMPLITUDE      = 10000000,
  parameter longint CLK_HZ         = 50000000,
  parameter int     HP_W           = 24,
  parameter int     OCT_MIN        = -4,
  parameter int     OCT_MAX        = 4,
  parameter int     RELEASE_CYCLES = 5000000
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [7:0]            key_data,
  input  logic                  key_valid,
  // sample_write is sample_ready delayed one cycle, registered together with
  // sample_out; a write happens on every cycle the controller allows one and
  // samples offered while sample_ready is low are simply dropped.
  input  logic                  sample_ready,
  output logic [AMP_W-1:0]      sample_out,
  output logic                  sample_write,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic [3:0]            octave,
  output logic                  sharp,
  output logic                  flat
);

  localparam logic signed [3:0] OCT_HI = 4'(OCT_MAX);
  localparam logic signed [3:0] OCT_LO = 4'(OCT_MIN);
  localparam int SUM_W = AMP_W + 4;

  parse_state_e      state_q, state_d;
  logic signed [3:0] oct_q;
  logic              key_hit;
  logic [3:0]        key_idx;
  logic              note_on, note_off, oct_up, oct_down, tog_sharp, tog_flat;

  always_comb begin
    key_hit = 1'b0;
    key_idx = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (key_data == KEY_TABLE[i[3:0]]) begin
        key_hit = 1'b1;
        key_idx = 4'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    note_on   = 1'b0;
    note_off  = 1'b0;
    oct_up    = 1'b0;
    oct_down  = 1'b0;
    tog_sharp = 1'b0;
    tog_flat  = 1'b0;
    if (key_valid) begin
      case (state_q)
        P_IDLE: begin
          if (key_data == SC_BREAK)    state_d = P_BRK;
          else if (key_data == SC_EXT) state_d = P_EXT;
          else                         note_on = key_hit;
        end
        P_BRK: begin
          note_off = key_hit;
          state_d  = P_IDLE;
        end
        P_EXT: begin
          state_d = P_IDLE;
          case (key_data)
            SC_BREAK: state_d   = P_EXT_BRK;
            SC_UP:    oct_up    = 1'b1;
            SC_DOWN:  oct_down  = 1'b1;
            SC_LEFT:  tog_flat  = 1'b1;
            SC_RIGHT: tog_sharp = 1'b1;
            default:  state_d   = P_IDLE;
          endcase
        end
        default: state_d = P_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= P_IDLE;
      oct_q   <= '0;
      sharp   <= 1'b0;
      flat    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (oct_up && oct_q < OCT_HI)   oct_q <= oct_q + 4'sd1;
      if (oct_down && oct_q > OCT_LO) oct_q <= oct_q - 4'sd1;
      if (tog_sharp) sharp <= !sharp;
      if (tog_flat)  flat  <= !flat;
    end
  end

  assign octave = oct_q;

  acc_e       cur_acc;
  logic [3:0] shamt;
  assign cur_acc = sharp ? SHARP : (flat ? FLAT : NAT);
  assign shamt   = oct_q[3] ? 4'(-oct_q) : oct_q;

  logic [AMP_W-1:0] contrib_v [NUM_VOICES];

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    localparam logic [HP_W-1:0] HP_NAT   = HP_W'(hp_calc(CLK_HZ, v, NAT));
    localparam logic [HP_W-1:0] HP_SHARP = HP_W'(hp_calc(CLK_HZ, v, SHARP));
    localparam logic [HP_W-1:0] HP_FLAT  = HP_W'(hp_calc(CLK_HZ, v, FLAT));

    logic [HP_W-1:0] base, hp_sel;

    always_comb begin
      case (cur_acc)
        SHARP:   base = HP_SHARP;
        FLAT:    base = HP_FLAT;
        default: base = HP_NAT;
      endcase
      hp_sel = oct_q[3] ? (base << shamt) : (base >> shamt);
    end

    synth_voice #(
      .AMP_W          (AMP_W),
      .AMPLITUDE      (AMPLITUDE),
      .HP_W           (HP_W),
      .RELEASE_CYCLES (RELEASE_CYCLES)
    ) u_voice (
      .clk      (CLOCK_50),
      .reset    (reset),
      .note_on  (note_on && (key_idx == 4'(v))),
      .note_off (note_off && (key_idx == 4'(v))),
      .hp_in    (hp_sel),
      .active   (voice_active[v]),
      .contrib  (contrib_v[v])
    );
  end

  logic signed [SUM_W-1:0] mix_sum;
  logic [AMP_W-1:0]        mix_sat;

  // The sum fits when its top five bits are all equal; otherwise clamp.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix_sum = mix_sum + SUM_W'($signed(contrib_v[i]));
    end
    if ((&mix_sum[SUM_W-1:AMP_W-1]) || !(|mix_sum[SUM_W-1:AMP_W-1]))
      mix_sat = mix_sum[AMP_W-1:0];
    else if (mix_sum[SUM_W-1])
      mix_sat = {1'b1, {(AMP_W-1){1'b0}}};
    else
      mix_sat = {1'b0, {(AMP_W-1){1'b1}}};
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sample_out   <= '0;
      sample_write <= 1'b0;
    end else begin
      sample_out   <= mix_sat;
      sample_write <= sample_ready;
    end
  end

endmodule
